// File: rtl/ibex_ascon_round_ctrl_pkg.sv
// Shared definitions for the Ascon permutation round controller.
//   ascon_state_t   : 320-bit permutation state, x0 in [63:0] ... x4 in [319:256]
//   ascon_fsm_e     : controller states IDLE / RUN / DONE
//   MaxRoundsDefault: default largest round count, also the round-constant base
//   ascon_rc()      : 8-bit round constant for round index i
package ibex_ascon_defines;

  localparam int unsigned MaxRoundsDefault = 12;

  typedef logic [319:0] ascon_state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ascon_fsm_e;

  // Upper nibble counts down while the lower nibble counts up.
  function automatic logic [7:0] ascon_rc(input logic [3:0] i);
    logic [3:0] hi;
    hi = 4'd15 - i;
    return {hi, i};
  endfunction

endpackage

// File: rtl/ibex_ascon_round_ctrl_if.sv
// Request/response bundle of the Ascon round controller.
//   start_i/rounds_i/state_i : permutation request, sampled on accept
//   flush_i                  : abort whatever is in progress
//   ready_o/busy_o/done_o    : IDLE / RUN / one-cycle completion
//   err_o                    : illegal round count, qualified by done_o
//   state_o                  : permuted state
// slave = controller side, master = requester side.
interface ibex_ascon_round_ctrl_if;
  import ibex_ascon_defines::*;

  logic         start_i;
  logic [3:0]   rounds_i;
  ascon_state_t state_i;
  logic         flush_i;
  logic         ready_o;
  logic         busy_o;
  logic         done_o;
  logic         err_o;
  ascon_state_t state_o;

  modport slave (
    input  start_i, rounds_i, state_i, flush_i,
    output ready_o, busy_o, done_o, err_o, state_o
  );

  modport master (
    output start_i, rounds_i, state_i, flush_i,
    input  ready_o, busy_o, done_o, err_o, state_o
  );
endinterface

// File: rtl/ibex_ascon_round_ctrl_round.sv
// One combinational Ascon round: constant addition, S-box layer, linear layer.
//   state_i : input state
//   idx_i   : round index i (selects the round constant)
//   state_o : state after the round
module ibex_ascon_round
  import ibex_ascon_defines::*;
(
  input  ascon_state_t state_i,
  input  logic [3:0]   idx_i,
  output ascon_state_t state_o
);

  function automatic logic [63:0] ror(input logic [63:0] v, input int unsigned s);
    return (v >> s) | (v << (64 - s));
  endfunction

  logic [63:0] x0, x1, x2, x3, x4;
  logic [63:0] y0, y1, y2, y3, y4;

  assign x0 = state_i[63:0];
  assign x1 = state_i[127:64];
  assign x2 = state_i[191:128] ^ {56'd0, ascon_rc(idx_i)};
  assign x3 = state_i[255:192];
  assign x4 = state_i[319:256];

  // S-box in algebraic normal form, applied to all 64 bit columns at once.
  assign y0 = (x4 & x1) ^ x3 ^ (x2 & x1) ^ x2 ^ (x1 & x0) ^ x1 ^ x0;
  assign y1 = x4 ^ (x3 & x2) ^ (x3 & x1) ^ x3 ^ (x2 & x1) ^ x2 ^ x1 ^ x0;
  assign y2 = ~((x4 & x3) ^ x4 ^ x2 ^ x1);
  assign y3 = (x4 & x0) ^ x4 ^ (x3 & x0) ^ x3 ^ x2 ^ x1 ^ x0;
  assign y4 = (x4 & x1) ^ x4 ^ x3 ^ (x1 & x0) ^ x1;

  assign state_o = {y4 ^ ror(y4, 7)  ^ ror(y4, 41),
                    y3 ^ ror(y3, 10) ^ ror(y3, 17),
                    y2 ^ ror(y2, 1)  ^ ror(y2, 6),
                    y1 ^ ror(y1, 61) ^ ror(y1, 39),
                    y0 ^ ror(y0, 19) ^ ror(y0, 28)};

endmodule

// File: rtl/ibex_ascon_round_ctrl.sv
// Ascon permutation round controller: accepts a 320-bit state and a round
// count n, runs rounds i = MaxRounds-n .. MaxRounds-1, then pulses done_o.
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus          : ibex_ascon_round_ctrl_if.slave (request, flush, status, result)
// Build option: define IBEX_ASCON_UNROLL2_EN to apply two chained rounds per
// RUN cycle (the last cycle of an odd count applies just one).
module ibex_ascon_round_ctrl
  import ibex_ascon_defines::*;
#(
  parameter int unsigned MaxRounds = MaxRoundsDefault
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  ibex_ascon_round_ctrl_if.slave bus
);

  localparam logic [3:0] MaxR = 4'(MaxRounds);

  ascon_fsm_e   fsm_q, fsm_d;
  ascon_state_t st_q, st_d, r0_out, rnd_out;
  logic [3:0]   idx_q, idx_d, cnt_q, cnt_d, adv;
  logic         err_q, err_d, rounds_ok, last;

  assign rounds_ok = (bus.rounds_i != 4'd0) && (bus.rounds_i <= MaxR);

  ibex_ascon_round u_round0 (.state_i(st_q), .idx_i(idx_q), .state_o(r0_out));

`ifdef IBEX_ASCON_UNROLL2_EN
  ascon_state_t r1_out;
  logic         two;

  ibex_ascon_round u_round1 (.state_i(r0_out), .idx_i(idx_q + 4'd1), .state_o(r1_out));

  // A single remaining round (odd n) takes only the first instance.
  assign two     = (cnt_q != 4'd1);
  assign adv     = two ? 4'd2 : 4'd1;
  assign rnd_out = two ? r1_out : r0_out;
  assign last    = (cnt_q <= 4'd2);
`else
  assign adv     = 4'd1;
  assign rnd_out = r0_out;
  assign last    = (cnt_q == 4'd1);
`endif

  always_comb begin
    fsm_d = fsm_q;
    st_d  = st_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    err_d = err_q;
    case (fsm_q)
      IDLE: begin
        if (bus.start_i) begin
          if (rounds_ok) begin
            fsm_d = RUN;
            st_d  = bus.state_i;
            idx_d = MaxR - bus.rounds_i;
            cnt_d = bus.rounds_i;
            err_d = 1'b0;
          end else begin
            // Bad count: report through DONE without touching the state.
            fsm_d = DONE;
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        st_d  = rnd_out;
        idx_d = idx_q + adv;
        cnt_d = cnt_q - adv;
        if (last) fsm_d = DONE;
      end
      DONE:    fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
    // Flush beats everything, including a same-cycle start.
    if (bus.flush_i) begin
      fsm_d = IDLE;
      st_d  = st_q;
      idx_d = idx_q;
      cnt_d = cnt_q;
      err_d = err_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fsm_q <= IDLE;
      st_q  <= '0;
      idx_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      fsm_q <= fsm_d;
      st_q  <= st_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign bus.ready_o = (fsm_q == IDLE);
  assign bus.busy_o  = (fsm_q == RUN);
  assign bus.done_o  = (fsm_q == DONE);
  assign bus.err_o   = (fsm_q == DONE) && err_q;
  assign bus.state_o = st_q;

endmodule

// File: doc/ibex_ascon_round_ctrl.md
IBEX_ASCON_ROUND_CTRL -- requirements
Module: ibex_ascon_round_ctrl

Interface
REQ-001 Parameter MaxRounds, default 12, SHALL set the largest accepted round count and the round-constant base.
REQ-002 Port clk_i, input, 1 bit, SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 Port rst_i, input, 1 bit, SHALL be a synchronous, active-high reset.
REQ-004 Port start_i, input, 1 bit, SHALL request a permutation; it is accepted only when ready_o=1.
REQ-005 Port rounds_i, input, 4 bits, SHALL give the round count n, sampled on accept.
REQ-006 Port state_i, input, 320 bits, SHALL carry words x0..x4 (64 bits each, x0 in [63:0]), sampled on accept.
REQ-007 Port flush_i, input, 1 bit, SHALL abort any operation in progress.
REQ-008 Port ready_o, output, 1 bit, SHALL be 1 only in IDLE.
REQ-009 Port busy_o, output, 1 bit, SHALL be 1 in RUN.
REQ-010 Port done_o, output, 1 bit, SHALL give a one-cycle completion pulse.
REQ-011 Port err_o, output, 1 bit, SHALL flag an illegal rounds_i, valid only with done_o.
REQ-012 Port state_o, output, 320 bits, SHALL present the permuted state, held from done_o until the next accept.

Function
REQ-013 FSM states SHALL be IDLE, RUN and DONE; the reset state SHALL be IDLE.
REQ-014 IDLE -> RUN SHALL occur on start_i with 1<=rounds_i<=MaxRounds: load the state register with state_i, set round index i=MaxRounds-n and set the remaining count to n.
REQ-015 IDLE -> DONE SHALL occur on start_i with rounds_i=0 or rounds_i>MaxRounds: state register unchanged, err_o=1 during DONE.
REQ-016 Each RUN cycle SHALL apply one round (constant addition, S-box layer, linear layer) to the state register, increment i and decrement the count.
REQ-017 The round constant SHALL be ((15-i)<<4)|i, 8 bits, XORed into x2[7:0].
REQ-018 RUN -> DONE SHALL occur in the cycle the last round is written.
REQ-019 DONE -> IDLE SHALL occur unconditionally after one cycle.
REQ-020 Latency SHALL be n+1 cycles from the accept edge to done_o=1 (n RUN cycles plus DONE).
REQ-021 A start_i in RUN or DONE SHALL be ignored; there is no queueing.
REQ-022 flush_i in any state SHALL force IDLE on the next edge: done_o stays 0 and the state register is unchanged.
REQ-023 When flush_i and start_i are asserted together, flush_i SHALL win and the start SHALL be dropped.
REQ-024 state_o SHALL be driven directly from the state register; no output is combinationally dependent on start_i.

Reset
REQ-025 rst_i=1 SHALL set the FSM to IDLE, the state register to 0, i and the count to 0, and ready_o=1, busy_o=0, done_o=0, err_o=0.
REQ-026 Reset during RUN SHALL abandon the operation with no done_o pulse.
REQ-027 Reset SHALL take priority over flush_i and start_i.

Configuration
REQ-028 Macro IBEX_ASCON_UNROLL2_EN, when defined, SHALL make each RUN cycle apply two chained rounds (i, i+1).
REQ-029 For odd n with IBEX_ASCON_UNROLL2_EN, the final RUN cycle SHALL apply only one round.
REQ-030 With IBEX_ASCON_UNROLL2_EN, latency SHALL be ceil(n/2)+1 cycles.
REQ-031 Without IBEX_ASCON_UNROLL2_EN, REQ-016 and REQ-020 SHALL hold and no second round instance SHALL exist.

Structure
REQ-032 ibex_ascon_defines SHALL hold the 320-bit state typedef, the FSM state enum, MaxRounds' default and the round-constant function.
REQ-033 A combinational sub-module ibex_ascon_round (inputs: state and 4-bit i; output: next state) SHALL implement one round; it is instantiated once, or twice when unrolled.

Verification
REQ-034 Reset, then start_i with n=12 and state 0 -> done_o exactly 13 cycles after accept; state_o matches the golden p12 model; err_o=0.
REQ-035 n=6 and n=8, random states -> first round constants 0x96 and 0xb4 respectively; latencies 7 and 9; outputs match the model.
REQ-036 rounds_i=0 and rounds_i=13 -> done_o 1 cycle after accept, err_o=1, state_o equals its previous value.
REQ-037 flush_i in RUN cycle 3 of a p12 -> ready_o=1 next cycle, no done_o; a following p6 completes correctly.
REQ-038 start_i held high throughout a p8 -> exactly one done_o; the next operation is accepted in the first IDLE cycle.
REQ-039 With IBEX_ASCON_UNROLL2_EN, n=7 -> done_o 5 cycles after accept; output equals the unrolled-off result.
